branch_cond_sequencer: RTL
==========================

// Module: branch_cond_sequencer
// PURPOSE
//  Multicycle controller that sequences conditional-branch resolution for the CPU datapath.
//  On a request from the main control FSM it issues a compare to the ALU and waits for its flags.
//  It then drives the branch-condition mux select and evaluates the condition.
//  It emits a one-cycle PC-write-conditional pulse when taken, plus done/taken/error status back to control.
// PARAMETERS
//  TIMEOUT_CYCLES  8   max cycles spent in WAIT for alu_done before abort (legal 1..255)
//  CNT_W           8   width of WAIT cycle counter (must hold TIMEOUT_CYCLES)
//  STAT_W          16  width of statistics counters (used only with BRANCH_STATS_EN)
// PORTS
//  clock          in   1       system clock, all state updates on rising edge
//  reset          in   1       synchronous, active-high
//  br_req         in   1       branch evaluation request from control FSM; sampled only in IDLE
//  br_type        in   2       00 BNE, 01 BEQ, 10 BGT, 11 BLE; latched on accept
//  alu_start      out  1       one-cycle pulse: ALU performs compare
//  alu_done       in   1       ALU flags valid this cycle
//  zero_flag      in   1       ALU zero
//  gt_flag        in   1       ALU greater-than
//  lt_flag        in   1       ALU less-than
//  eq_flag        in   1       ALU equal
//  cond_sel       out  2       branch-condition mux select = latched br_type
//  pc_write_cond  out  1       one-cycle pulse: load PC with branch target
//  br_done        out  1       one-cycle pulse: evaluation finished
//  br_taken       out  1       valid with br_done: condition true
//  br_err         out  1       valid with br_done: ALU timeout, branch suppressed
//  busy           out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset values: state IDLE; all outputs 0, including cond_sel=2'b00; counters and latched flags 0.
//  States: IDLE -> ISSUE -> WAIT -> RESOLVE -> IDLE.
//  IDLE: br_req=1 at an edge latches br_type and moves to ISSUE. br_req=0 stays in IDLE.
//  ISSUE (1 cycle): alu_start=1.
//   - alu_done=1 here (zero-latency ALU) latches flags and goes to RESOLVE.
//   - Otherwise goes to WAIT with counter cleared.
//  WAIT:
//   - alu_done=1 latches flags and goes to RESOLVE.
//   - Otherwise counter increments.
//   - Counter reaching TIMEOUT_CYCLES with no alu_done goes to RESOLVE with error set.
//   - alu_done in the expiry cycle wins over timeout: no error.
//  Condition on latched flags: 00 ~zero; 01 zero; 10 gt; 11 lt|eq.
//  RESOLVE (1 cycle): br_done=1; br_taken=cond & ~err; pc_write_cond=br_taken; br_err=err; then IDLE.
//  Minimum latency: br_req accepted at edge 0 -> alu_start in cycle 1 -> br_done in cycle 2.
//  busy=1 in ISSUE, WAIT and RESOLVE.
//  br_req outside IDLE (including the RESOLVE cycle) is ignored; no queueing; requester must re-assert.
//  br_type changes after accept are ignored. cond_sel holds the latched value until the next accept.
//  alu_done outside ISSUE/WAIT is ignored.
//  Reset mid-operation: next edge forces IDLE and zeroes all outputs; no pc_write_cond is produced for the aborted branch.
//  pc_write_cond never asserts outside RESOLVE and never asserts together with br_err.
// CONFIGURATION
//  BRANCH_STATS_EN defined:
//   - adds outputs stat_taken [STAT_W] and stat_not_taken [STAT_W];
//   - on each br_done: increments stat_taken if taken, else stat_not_taken (timeouts count as not taken);
//   - saturate at all-ones; cleared by reset.
//  BRANCH_STATS_EN undefined: those ports and counters do not exist; all other behaviour identical.
// TESTING
//  T1 BEQ, zero=1, alu_done in ISSUE
//     -> br_done at cycle 2, br_taken=1, pc_write_cond 1-cycle pulse, cond_sel=01.
//  T2 BNE, alu_done 3 cycles after alu_start, zero=1
//     -> br_done=1, br_taken=0, pc_write_cond stays 0, busy for 5 cycles.
//  T3 BLE with lt=0 eq=1 -> taken. BGT with gt=0 -> not taken. Flags changing after alu_done do not alter result.
//  T4 TIMEOUT_CYCLES=8, alu_done never
//     -> br_done with br_err=1, br_taken=0, no pc_write_cond.
//     Repeat with alu_done on the 8th WAIT cycle -> br_err=0.
//  T5 br_req held high during busy and in the RESOLVE cycle -> no second accept until IDLE.
//     reset asserted in WAIT -> IDLE next cycle, all outputs 0, no pulse.
//  T6 (BRANCH_STATS_EN) 3 taken + 2 not-taken + 1 timeout -> stat_taken=3, stat_not_taken=3.
//     Preload to all-ones -> counters hold.

Source files
------------

// File: rtl/branch_cond_sequencer.sv
// Branch-condition sequencer: IDLE->ISSUE->WAIT->RESOLVE, br_done 2 cycles after accept at best, ALU timeout aborts.
// No queueing: br_req is only sampled in IDLE. Optional BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_cond_sequencer #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = 8,
  parameter int STAT_W         = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_br_req,
  input  logic [1:0]        i_br_type,
  output logic              o_alu_start,
  input  logic              i_alu_done,
  input  logic              i_zero_flag,
  input  logic              i_gt_flag,
  input  logic              i_lt_flag,
  input  logic              i_eq_flag,
  output logic [1:0]        o_cond_sel,
  output logic              o_pc_write_cond,
  output logic              o_br_done,
  output logic              o_br_taken,
  output logic              o_br_err,
`ifdef BRANCH_STATS_EN
  output logic [STAT_W-1:0] o_stat_taken,
  output logic [STAT_W-1:0] o_stat_not_taken,
`endif
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_WAIT    = 2'b10,
    S_RESOLVE = 2'b11
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255 ||
      TIMEOUT_CYCLES >= (1 << CNT_W) || STAT_W < 1) begin : g_bad_param
    $error("branch_cond_sequencer: illegal parameter combination");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_type;
  logic             r_zero;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;
  logic             r_err;
  logic             w_latch_flags;
  logic             w_timeout;
  logic             w_cond;

  always_comb begin
    w_next_state  = r_state;
    w_latch_flags = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_br_req) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_alu_done) begin
          w_latch_flags = 1'b1;
          w_next_state  = S_RESOLVE;
        end else begin
          w_next_state  = S_WAIT;
        end
      end
      S_WAIT: begin
        // alu_done in the final allowed cycle takes priority over the timeout
        if (i_alu_done) begin
          w_latch_flags = 1'b1;
          w_next_state  = S_RESOLVE;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout     = 1'b1;
          w_next_state  = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_type  <= 2'b00;
      r_zero  <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && i_br_req) begin
        r_type <= i_br_type;
        r_err  <= 1'b0;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT && !i_alu_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_latch_flags) begin
        r_zero <= i_zero_flag;
        r_gt   <= i_gt_flag;
        r_lt   <= i_lt_flag;
        r_eq   <= i_eq_flag;
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  always_comb begin
    case (r_type)
      2'b00:   w_cond = ~r_zero;
      2'b01:   w_cond = r_zero;
      2'b10:   w_cond = r_gt;
      default: w_cond = r_lt | r_eq;
    endcase
  end

  assign o_alu_start     = (r_state == S_ISSUE);
  assign o_busy          = (r_state != S_IDLE);
  assign o_br_done       = (r_state == S_RESOLVE);
  assign o_br_err        = o_br_done & r_err;
  assign o_br_taken      = o_br_done & w_cond & ~r_err;
  assign o_pc_write_cond = o_br_taken;
  assign o_cond_sel      = r_type;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] r_stat_taken;
  logic [STAT_W-1:0] r_stat_not_taken;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stat_taken     <= '0;
      r_stat_not_taken <= '0;
    end else if (o_br_done) begin
      if (o_br_taken) begin
        if (r_stat_taken != '1) r_stat_taken <= r_stat_taken + 1'b1;
      end else begin
        if (r_stat_not_taken != '1) r_stat_not_taken <= r_stat_not_taken + 1'b1;
      end
    end
  end

  assign o_stat_taken     = r_stat_taken;
  assign o_stat_not_taken = r_stat_not_taken;
`endif

endmodule
